// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: prescaled one-shot/periodic interval timer sequencer.
// Optional irq_ack/irq ports with sticky irq when INTERVAL_TIMER_CTRL_IRQ_EN is defined.
module interval_timer_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      term,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef INTERVAL_TIMER_CTRL_IRQ_EN
    input  logic                  irq_ack,
    output logic                  irq,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] count_nxt, term_q, term_nxt;
    logic [PRESCALE_W-1:0] pre, pre_nxt, presc_q, presc_nxt;
    logic mode_q, mode_nxt, tick_nxt, done_nxt;
    assign busy = (state == RUN);
    // A launch (from IDLE or as a restart) takes priority over any tick due this cycle.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pre_nxt   = pre;
        mode_nxt  = mode_q;
        term_nxt  = term_q;
        presc_nxt = presc_q;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (start && !stop) begin
            state_nxt = RUN;
            mode_nxt  = mode;
            term_nxt  = term;
            presc_nxt = prescale;
            count_nxt = '0;
            pre_nxt   = '0;
        end else if (state == RUN) begin
            if (stop) begin
                state_nxt = IDLE;
            end else if (pre == presc_q) begin
                pre_nxt  = '0;
                tick_nxt = 1'b1;
                if (count != term_q) begin
                    count_nxt = count + WIDTH'(1);
                end else begin
                    done_nxt = 1'b1;
                    if (mode_q) count_nxt = '0;
                    else state_nxt = IDLE;
                end
            end else begin
                pre_nxt = pre + PRESCALE_W'(1);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (!clear) begin
            state   <= IDLE;
            count   <= '0;
            pre     <= '0;
            mode_q  <= 1'b0;
            term_q  <= '0;
            presc_q <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            pre     <= pre_nxt;
            mode_q  <= mode_nxt;
            term_q  <= term_nxt;
            presc_q <= presc_nxt;
            tick    <= tick_nxt;
            done    <= done_nxt;
        end
    end
`ifdef INTERVAL_TIMER_CTRL_IRQ_EN
    // Setting on a new done wins over a coincident acknowledge.
    always_ff @(posedge clock) begin
        if (!clear) irq <= 1'b0;
        else irq <= done_nxt ? 1'b1 : (irq_ack ? 1'b0 : irq);
    end
`endif
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed plus random stimulus against an elapsed-time reference model.
module tb_interval_timer_ctrl;
    logic clock = 1'b0;
    logic clear = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [7:0] term = '0, prescale = '0;
    logic [7:0] count;
    logic tick, busy, done;
    logic irq_ack = 1'b0;
`ifdef INTERVAL_TIMER_CTRL_IRQ_EN
    logic irq;
`endif
    int passes = 0, total = 0;
    // Reference model: time since launch, latched values, and derived outputs.
    bit m_run = 0, m_mode = 0, m_tick = 0, m_done = 0, m_irq = 0;
    int m_k = 0, m_t = 0, m_p = 0, m_count = 0;

    interval_timer_ctrl #(.WIDTH(8), .PRESCALE_W(8)) dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .mode(mode),
        .term(term), .prescale(prescale),
`ifdef INTERVAL_TIMER_CTRL_IRQ_EN
        .irq_ack(irq_ack), .irq(irq),
`endif
        .count(count), .tick(tick), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Elapsed-time view: after k RUN cycles, n = k/(P+1) ticks have happened.
    task automatic model_edge();
        int n;
        if (!clear) begin
            m_run = 0; m_mode = 0; m_tick = 0; m_done = 0; m_irq = 0;
            m_k = 0; m_t = 0; m_p = 0; m_count = 0;
            return;
        end
        m_tick = 0;
        m_done = 0;
        if (start && !stop) begin
            m_run = 1; m_k = 0; m_mode = mode; m_t = term; m_p = prescale; m_count = 0;
        end else if (m_run && stop) begin
            m_run = 0;
        end else if (m_run) begin
            m_k++;
            n = m_k / (m_p + 1);
            m_tick = (m_k % (m_p + 1)) == 0;
            if (m_mode) begin
                m_count = n % (m_t + 1);
                m_done = m_tick && (n % (m_t + 1) == 0);
            end else begin
                m_count = (n > m_t) ? m_t : n;
                m_done = m_tick && (n == m_t + 1);
                if (m_done) m_run = 0;
            end
        end
        if (m_done) m_irq = 1;
        else if (irq_ack) m_irq = 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        chk("count", 32'(count), 32'(m_count));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
`ifdef INTERVAL_TIMER_CTRL_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic launch(input logic md, input int t, input int p);
        mode = md; term = 8'(t); prescale = 8'(p); start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        run(2);
        chk("reset_count", 32'(count), 0);
        clear = 1'b1;
        // One-shot, term 3, prescale 1: done after edge 8.
        launch(1'b0, 3, 1);
        run(10);
        chk("oneshot_hold", 32'(count), 3);
        chk("oneshot_idle", 32'(busy), 0);
        // Periodic, term 2, prescale 0.
        launch(1'b1, 2, 0);
        run(9);
        chk("periodic_busy", 32'(busy), 1);
        // Stop at count 2 freezes the count.
        launch(1'b0, 5, 0);
        run(2);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run(3);
        chk("stop_frozen", 32'(count), 2);
        // start and stop together from IDLE.
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        chk("conflict_idle", 32'(busy), 0);
        // Restart mid-run latches the new term.
        launch(1'b0, 9, 1);
        run(3);
        launch(1'b0, 4, 0);
        chk("restart_zero", 32'(count), 0);
        run(8);
        chk("restart_term", 32'(count), 4);
        // term 0, one-shot, prescale 4.
        launch(1'b0, 0, 4);
        run(6);
        // Periodic term 0: done every cycle, ack coincident with done.
        launch(1'b1, 0, 0);
        irq_ack = 1'b1;
        run(4);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run(2);
        irq_ack = 1'b0;
        // Reset mid-run.
        launch(1'b1, 7, 2);
        run(5);
        clear = 1'b0;
        run(2);
        chk("midrun_reset_busy", 32'(busy), 0);
        clear = 1'b1;
        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 29) == 0);
            clear = ($urandom_range(0, 199) != 0);
            irq_ack = ($urandom_range(0, 7) == 0);
            mode = 1'($urandom);
            term = 8'($urandom_range(0, 5));
            prescale = 8'($urandom_range(0, 3));
            cycle();
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
